// File: rtl/oam_dma.sv
// Sprite DMA: a write to DMA_ADDR stalls the CPU and copies one 256-byte page of work RAM
// into OAM through 256 chip-select-strobed writes to the OAMDATA register.
module oam_dma #(
   parameter logic [15:0] DMA_ADDR    = 16'h4014,
   parameter logic [2:0]  OAMDATA_SEL = 3'd4,
   parameter int unsigned GAP_CYCLES  = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] cpu_addr,
   input  logic        cpu_wr,
   input  logic [7:0]  cpu_data,
   output logic        cpu_stall,
   output logic [15:0] mem_addr,
   output logic        mem_rd,
   input  logic [7:0]  mem_data,
   output logic        ppu_cs_n,
   output logic [2:0]  ppu_reg_addr,
   output logic        ppu_we,
   output logic [7:0]  ppu_data,
   output logic        done
);

   localparam logic [2:0] StIdle    = 3'd0;
   localparam logic [2:0] StAlign2  = 3'd1;
   localparam logic [2:0] StAlign   = 3'd2;
   localparam logic [2:0] StRead    = 3'd3;
   localparam logic [2:0] StCapture = 3'd4;
   localparam logic [2:0] StWrite   = 3'd5;
   localparam logic [2:0] StGap     = 3'd6;
   localparam logic [2:0] StDone    = 3'd7;

   localparam logic [2:0] GapLast = 3'(GAP_CYCLES - 1);

   logic [2:0] state_q, state_d;
   logic [7:0] page_q, page_d;
   logic [7:0] idx_q, idx_d;
   logic [2:0] gap_cnt_q, gap_cnt_d;
   logic [7:0] data_q, data_d;
   logic       parity_q;

   always_comb begin
      state_d   = state_q;
      page_d    = page_q;
      idx_d     = idx_q;
      gap_cnt_d = gap_cnt_q;
      data_d    = data_q;
      case (state_q)
         StIdle: begin
            if (cpu_wr && (cpu_addr == DMA_ADDR)) begin
               page_d  = cpu_data;
               idx_d   = 8'd0;
               // an odd-cycle trigger burns one extra cycle to realign with the CPU
               state_d = parity_q ? StAlign2 : StAlign;
            end
         end
         StAlign2:  state_d = StAlign;
         StAlign:   state_d = StRead;
         StRead:    state_d = StCapture;
         StCapture: begin
            data_d  = mem_data;
            state_d = StWrite;
         end
         StWrite: begin
            gap_cnt_d = 3'd0;
            state_d   = StGap;
         end
         StGap: begin
            if (gap_cnt_q == GapLast) begin
               gap_cnt_d = 3'd0;
               if (idx_q == 8'hFF) begin
                  state_d = StDone;
               end else begin
                  idx_d   = idx_q + 8'd1;
                  state_d = StRead;
               end
            end else begin
               gap_cnt_d = gap_cnt_q + 3'd1;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StIdle;
         page_q    <= 8'd0;
         idx_q     <= 8'd0;
         gap_cnt_q <= 3'd0;
         data_q    <= 8'd0;
         parity_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         page_q    <= page_d;
         idx_q     <= idx_d;
         gap_cnt_q <= gap_cnt_d;
         data_q    <= data_d;
         parity_q  <= ~parity_q;
      end
   end

   // Moore outputs decoded from registered state only
   assign cpu_stall    = (state_q != StIdle) && (state_q != StDone);
   assign mem_rd       = (state_q == StRead);
   assign mem_addr     = mem_rd ? {page_q, idx_q} : 16'h0000;
   assign ppu_cs_n     = (state_q != StWrite);
   assign ppu_we       = (state_q == StCapture) || (state_q == StWrite);
   assign ppu_reg_addr = OAMDATA_SEL;
   assign ppu_data     = data_q;
   assign done         = (state_q == StDone);

endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma: one instance with the default gap, one with a 3-cycle gap,
// a negedge monitor on the selected instance, and immediate-assertion checks.
module tb_oam_dma;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_data;
   logic        cpu_wr1, cpu_wr3;

   logic        stall1, rd1, cs_n1, we1, done1;
   logic [15:0] addr1;
   logic [2:0]  ra1;
   logic [7:0]  pd1, md1;
   logic        stall3, rd3, cs_n3, we3, done3;
   logic [15:0] addr3;
   logic [2:0]  ra3;
   logic [7:0]  pd3, md3;

   always #5 clk = ~clk;

   oam_dma dut1 (
      .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_wr(cpu_wr1), .cpu_data(cpu_data),
      .cpu_stall(stall1), .mem_addr(addr1), .mem_rd(rd1), .mem_data(md1), .ppu_cs_n(cs_n1),
      .ppu_reg_addr(ra1), .ppu_we(we1), .ppu_data(pd1), .done(done1)
   );

   oam_dma #(.GAP_CYCLES(3)) dut3 (
      .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_wr(cpu_wr3), .cpu_data(cpu_data),
      .cpu_stall(stall3), .mem_addr(addr3), .mem_rd(rd3), .mem_data(md3), .ppu_cs_n(cs_n3),
      .ppu_reg_addr(ra3), .ppu_we(we3), .ppu_data(pd3), .done(done3)
   );

   // RAM contents: page $02 holds i^A5; other pages are offset by (page^$02)
   function automatic logic [7:0] ram(input logic [15:0] a);
      return a[7:0] ^ 8'hA5 ^ a[15:8] ^ 8'h02;
   endfunction

   always @(posedge clk) begin
      if (rd1) md1 <= ram(addr1);
      if (rd3) md3 <= ram(addr3);
   end

   logic        sel = 1'b0;
   logic        m_stall, m_rd, m_cs, m_we, m_done;
   logic [15:0] m_addr;
   logic [2:0]  m_ra;
   logic [7:0]  m_pd;

   always_comb begin
      m_stall = sel ? stall3 : stall1;
      m_rd    = sel ? rd3    : rd1;
      m_cs    = sel ? cs_n3  : cs_n1;
      m_we    = sel ? we3    : we1;
      m_done  = sel ? done3  : done1;
      m_addr  = sel ? addr3  : addr1;
      m_ra    = sel ? ra3    : ra1;
      m_pd    = sel ? pd3    : pd1;
   end

   logic        clr = 1'b0;
   int          stall_cnt, stall_rise, done_cnt, rd_cnt, wr_cnt, low_cnt, long_low, bad_wr;
   int          high_run, min_high;
   logic        prev_cs, prev_stall;
   logic [7:0]  wr_data [0:511];
   logic [15:0] rd_addr [0:511];

   always @(negedge clk) begin
      if (clr) begin
         stall_cnt = 0; stall_rise = 0; done_cnt = 0; rd_cnt = 0; wr_cnt = 0;
         low_cnt = 0; long_low = 0; bad_wr = 0; high_run = 0; min_high = 1000;
         prev_cs = 1'b1; prev_stall = 1'b0;
         for (int i = 0; i < 512; i++) begin
            wr_data[i] = 8'hxx;
            rd_addr[i] = 16'hxxxx;
         end
      end else begin
         if (m_stall) stall_cnt++;
         if (m_stall && !prev_stall) stall_rise++;
         if (m_done) done_cnt++;
         if (m_rd) begin
            if (rd_cnt < 512) rd_addr[rd_cnt] = m_addr;
            rd_cnt++;
         end
         if (!m_cs) begin
            low_cnt++;
            if (!prev_cs) long_low++;
         end
         if (!m_cs && prev_cs) begin
            if (wr_cnt < 512) wr_data[wr_cnt] = m_pd;
            if (!m_we || m_ra !== 3'd4) bad_wr++;
            if (high_run < min_high) min_high = high_run;
            wr_cnt++;
         end
         high_run   = m_cs ? high_run + 1 : 0;
         prev_cs    = m_cs;
         prev_stall = m_stall;
      end
   end

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_mon();
      clr = 1'b1;
      tick();
      clr = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic cpu_write(input logic [15:0] a, input logic [7:0] d, input logic to3);
      cpu_addr = a;
      cpu_data = d;
      if (to3) cpu_wr3 = 1'b1;
      else cpu_wr1 = 1'b1;
      tick();
      cpu_wr1 = 1'b0;
      cpu_wr3 = 1'b0;
   endtask

   task automatic wait_done();
      for (int k = 0; k < 4000 && done_cnt == 0; k++) tick();
      repeat (4) tick();
   endtask

   task automatic check_run(input string tag, input int exp_stall, input logic [7:0] page);
      int data_err;
      int addr_err;
      logic [7:0] i8;
      data_err = 0;
      addr_err = 0;
      for (int i = 0; i < 256; i++) begin
         i8 = 8'(i);
         if (wr_data[i] !== (i8 ^ 8'hA5 ^ page ^ 8'h02)) data_err++;
         if (rd_addr[i] !== {page, i8}) addr_err++;
      end
      chk({tag, " stall_len"}, stall_cnt, exp_stall);
      chk({tag, " stall_runs"}, stall_rise, 1);
      chk({tag, " writes"}, wr_cnt, 256);
      chk({tag, " reads"}, rd_cnt, 256);
      chk({tag, " done_pulses"}, done_cnt, 1);
      chk({tag, " bad_write_strobe"}, bad_wr, 0);
      chk({tag, " cs_low_gt1"}, long_low, 0);
      chk({tag, " data_errors"}, data_err, 0);
      chk({tag, " addr_errors"}, addr_err, 0);
   endtask

   initial begin
      reset = 1'b1; cpu_addr = 16'h0000; cpu_data = 8'h00; cpu_wr1 = 1'b0; cpu_wr3 = 1'b0;
      tick();
      tick();
      chk("rst cpu_stall", stall1, 0);
      chk("rst mem_rd", rd1, 0);
      chk("rst mem_addr", addr1, 16'h0000);
      chk("rst ppu_cs_n", cs_n1, 1);
      chk("rst ppu_we", we1, 0);
      chk("rst ppu_reg_addr", ra1, 3'd4);
      chk("rst ppu_data", pd1, 8'h00);
      chk("rst done", done1, 0);
      chk("rst gap3 cs_n", cs_n3, 1);

      // even-parity trigger, page $02
      clear_mon();
      do_reset();
      cpu_write(16'h4014, 8'h02, 1'b0);
      chk("even stall_next_cycle", stall1, 1);
      wait_done();
      check_run("even", 1025, 8'h02);

      // odd-parity trigger: one idle cycle after reset flips parity
      clear_mon();
      do_reset();
      tick();
      cpu_write(16'h4014, 8'h02, 1'b0);
      chk("odd stall_next_cycle", stall1, 1);
      wait_done();
      check_run("odd", 1026, 8'h02);

      // second $4014 write mid-transfer is ignored
      clear_mon();
      do_reset();
      cpu_write(16'h4014, 8'h02, 1'b0);
      for (int k = 0; k < 2000 && wr_cnt < 100; k++) tick();
      cpu_write(16'h4014, 8'h07, 1'b0);
      wait_done();
      check_run("retrig", 1025, 8'h02);

      // reset while byte 50 is in WRITE abandons the transfer
      clear_mon();
      do_reset();
      cpu_write(16'h4014, 8'h02, 1'b0);
      for (int k = 0; k < 2000 && !(cs_n1 == 1'b0 && wr_cnt == 50); k++) tick();
      chk("midrst reached_write", {31'd0, (cs_n1 == 1'b0 && wr_cnt == 50)}, 1);
      reset = 1'b1;
      tick();
      chk("midrst ppu_cs_n", cs_n1, 1);
      chk("midrst cpu_stall", stall1, 0);
      chk("midrst ppu_we", we1, 0);
      chk("midrst mem_rd", rd1, 0);
      reset = 1'b0;
      repeat (5) tick();
      chk("midrst stays_idle", stall1, 0);
      chk("midrst no_done", done_cnt, 0);
      clear_mon();
      do_reset();
      cpu_write(16'h4014, 8'h03, 1'b0);
      wait_done();
      check_run("page03", 1025, 8'h03);

      // trigger on the reset edge is lost
      reset = 1'b1;
      cpu_addr = 16'h4014;
      cpu_data = 8'h02;
      cpu_wr1 = 1'b1;
      tick();
      reset = 1'b0;
      cpu_wr1 = 1'b0;
      tick();
      chk("rst_trig lost", stall1, 0);

      // 3-cycle gap, page $FF up to $FFFF
      sel = 1'b1;
      clear_mon();
      do_reset();
      cpu_write(16'h4014, 8'hFF, 1'b1);
      wait_done();
      check_run("gap3", 1537, 8'hFF);
      chk("gap3 min_high_ge3", {31'd0, (min_high >= 3)}, 1);
      chk("gap3 last_addr", rd_addr[255], 16'hFFFF);
      sel = 1'b0;

      // near-miss addresses and a read of $4014
      clear_mon();
      do_reset();
      cpu_write(16'h4013, 8'h02, 1'b0);
      cpu_write(16'h4015, 8'h02, 1'b0);
      cpu_addr = 16'h4014;
      tick();
      repeat (6) tick();
      chk("nomatch stall_cycles", stall_cnt, 0);
      chk("nomatch reads", rd_cnt, 0);
      chk("nomatch cs_low", low_cnt, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/oam_dma.md
Name: oam_dma

Overview:
- Sprite DMA engine: the CPU-side initiator for the PPU register bus.
- A CPU write to $4014 latches a page number, stalls the CPU, then copies 256 bytes from CPU memory $XX00-$XXFF into OAM.
- The copy is 256 writes to PPU register 4 (OAMDATA), using the same active-low, edge-triggered chip-select protocol the CPU uses.
- Sits between the CPU bus, the work-RAM read port and the PPU register interface. The top-level bus mux selects the DMA's PPU-bus drive while cpu_stall is high.

Parameters:
- DMA_ADDR, 16'h4014, CPU address that triggers a transfer.
- OAMDATA_SEL, 3'd4, register select driven on ppu_reg_addr.
- GAP_CYCLES, 1, cycles ppu_cs_n is held high between writes; legal range 1-7.

Ports:
- clk  in  1  system clock, all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- cpu_addr  in  16  CPU address bus.
- cpu_wr  in  1  CPU write strobe; qualifies cpu_addr/cpu_data.
- cpu_data  in  8  CPU write data; the page number on a trigger.
- cpu_stall  out  1  holds the CPU (RDY low) while high.
- mem_addr  out  16  work-RAM read address = {page, idx}.
- mem_rd  out  1  read strobe; mem_data valid the following cycle.
- mem_data  in  8  work-RAM read data.
- ppu_cs_n  out  1  PPU register chip select, active low.
- ppu_reg_addr  out  3  PPU register select.
- ppu_we  out  1  PPU register write enable.
- ppu_data  out  8  byte to OAMDATA.
- done  out  1  one-cycle pulse when the transfer completes.

Behaviour:
- Reset (synchronous, overrides everything, including mid-transfer):
  - state=IDLE, idx=0, page=0, gap_cnt=0, parity=0.
  - Outputs: cpu_stall=0, mem_rd=0, mem_addr=0, ppu_cs_n=1, ppu_we=0, ppu_reg_addr=OAMDATA_SEL, ppu_data=0, done=0.
  - A partial transfer is abandoned. OAM keeps the bytes already written.
- parity: a free-running bit that toggles every clk. It models the CPU odd/even cycle.
- Trigger: in IDLE, at a posedge with cpu_wr=1 and cpu_addr==DMA_ADDR:
  - page<=cpu_data, idx<=0.
  - Next state is ALIGN2 if parity=1, else ALIGN.
- Triggers are ignored in any state other than IDLE. A $4014 write while busy does not restart or change the page.
- States and transitions:
  - ALIGN2 -> ALIGN: one extra dummy cycle, for odd-cycle alignment.
  - ALIGN -> READ: one dummy cycle.
  - READ -> CAPTURE: mem_rd=1, mem_addr={page,idx}.
  - CAPTURE -> WRITE: ppu_data<=mem_data (registered), ppu_we=1, ppu_cs_n=1.
  - WRITE -> GAP: ppu_cs_n=0, ppu_we=1, ppu_reg_addr=OAMDATA_SEL, ppu_data held. Exactly one cycle low.
  - GAP: ppu_cs_n=1, ppu_we=0; stays GAP_CYCLES cycles via gap_cnt. Exit goes to READ with idx+1 if idx!=255, else to DONE.
  - DONE -> IDLE: done=1 for one cycle, cpu_stall=0.
- Outputs are Moore: decoded from the registered state and data registers, never combinationally from inputs.
- cpu_stall=1 in ALIGN2, ALIGN, READ, CAPTURE, WRITE and GAP; 0 in IDLE and DONE. It rises the cycle after the trigger edge.
- ppu_cs_n is high for at least GAP_CYCLES cycles before every low cycle. The receiver detects each write on the high-to-low edge, so every byte produces exactly one OAMDATA write.
- OAM address is not driven: the PPU auto-increments OAMADDR on each OAMDATA write. The copy starts at the current OAMADDR and wraps modulo 256 in the PPU.
- idx is 8-bit. The 255 test selects DONE, so idx never wraps into a second pass.
- mem_addr low byte = idx and high byte = page; no carry into page.
- Stall length = 1 + parity_at_trigger + 256*(3+GAP_CYCLES). With GAP_CYCLES=1 this is 1025 (even) or 1026 (odd).
- A trigger on the same edge as reset is lost (reset wins).

Test Plan:
- Even trigger, page $02, RAM $0200+i=i^8'hA5, GAP_CYCLES=1 -> cpu_stall high exactly 1025 cycles; 256 ppu_cs_n low pulses carrying bytes A5,A4,...; done pulses once; mem_addr swept $0200-$02FF.
- Same with trigger on odd parity -> cpu_stall high 1026 cycles; data sequence identical.
- Second $4014 write (data $07) at byte 100 -> ignored; all 256 addresses remain $02xx; single done.
- Reset asserted at byte 50, in WRITE -> next cycle ppu_cs_n=1, cpu_stall=0, state IDLE, no done. A new trigger with page $03 then completes a full 256-byte run from $0300.
- GAP_CYCLES=3, page $FF -> each cs_n low pulse preceded by ≥3 high cycles; stall = 1+256*6 = 1537 (even); last mem_addr $FFFF; no wrap into page $00.
- Write to $4013 or $4015 with cpu_wr=1, and a read of $4014 with cpu_wr=0 -> no stall, no mem_rd, ppu_cs_n stays 1.
